// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control-unit handshake plus the instruction-memory read port.
// The fetch unit connects through "master"; the control unit / memory side uses "slave".
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              fetch_en;
  logic              ir_ack;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       IR;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  modport master (
    input  fetch_en, ir_ack, pc_load, pc_in, mem_ack, mem_rdata,
    output mem_addr, mem_req, IR, ir_valid, pc, fetch_err
  );

  modport slave (
    output fetch_en, ir_ack, pc_load, pc_in, mem_ack, mem_rdata,
    input  mem_addr, mem_req, IR, ir_valid, pc, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// holds the fetched word in IR until the control unit consumes it.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                TIMEOUT  = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  instr_fetch_unit_if.master  io_fetch
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic              r_fetch_err;
  logic              r_pend;
  logic [ADDR_W-1:0] r_target;
  logic [CNT_W-1:0]  r_wait_cnt;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic              w_mem_req_nxt;
  logic [31:0]       w_ir_nxt;
  logic              w_ir_valid_nxt;
  logic              w_fetch_err_nxt;
  logic              w_pend_nxt;
  logic [ADDR_W-1:0] w_target_nxt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic [ADDR_W-1:0] w_pc_in_al;
  logic              w_pend_any;
  logic [ADDR_W-1:0] w_target_sel;

  // A redirect arriving in the same cycle as the ack/timeout counts as already pending.
  assign w_pc_in_al   = {io_fetch.pc_in[ADDR_W-1:2], 2'b00};
  assign w_pend_any   = r_pend | io_fetch.pc_load;
  assign w_target_sel = io_fetch.pc_load ? w_pc_in_al : r_target;

  // State and datapath registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_mem_addr  <= RESET_PC;
      r_mem_req   <= 1'b0;
      r_ir        <= 32'h0000_0000;
      r_ir_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
      r_pend      <= 1'b0;
      r_target    <= {ADDR_W{1'b0}};
      r_wait_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_ir        <= w_ir_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
      r_fetch_err <= w_fetch_err_nxt;
      r_pend      <= w_pend_nxt;
      r_target    <= w_target_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_req_nxt   = r_mem_req;
    w_ir_nxt        = r_ir;
    w_ir_valid_nxt  = r_ir_valid;
    w_fetch_err_nxt = r_fetch_err;
    w_pend_nxt      = r_pend;
    w_target_nxt    = r_target;
    w_wait_cnt_nxt  = r_wait_cnt;

    case (r_state)
      ST_IDLE: begin
        w_mem_req_nxt = 1'b0;
        if (io_fetch.pc_load) begin
          w_pc_nxt = w_pc_in_al;
        end else if (io_fetch.fetch_en) begin
          w_mem_addr_nxt = r_pc;
          w_mem_req_nxt  = 1'b1;
          w_wait_cnt_nxt = {CNT_W{1'b0}};
          w_state_nxt    = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (io_fetch.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_pend_nxt    = 1'b0;
          if (w_pend_any) begin
            w_pc_nxt    = w_target_sel;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ir_nxt       = io_fetch.mem_rdata;
            w_pc_nxt       = r_pc + PC_STEP;
            w_ir_valid_nxt = 1'b1;
            w_state_nxt    = ST_VALID;
          end
        end else if (r_wait_cnt == CNT_MAX) begin
          w_mem_req_nxt   = 1'b0;
          w_fetch_err_nxt = 1'b1;
          w_pend_nxt      = 1'b0;
          w_state_nxt     = ST_IDLE;
          if (w_pend_any) begin
            w_pc_nxt = w_target_sel;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
          w_pend_nxt     = w_pend_any;
          w_target_nxt   = w_target_sel;
        end
      end

      ST_VALID: begin
        if (io_fetch.pc_load) begin
          w_pc_nxt       = w_pc_in_al;
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else if (io_fetch.ir_ack) begin
          w_ir_valid_nxt = 1'b0;
          if (io_fetch.fetch_en) begin
            w_mem_addr_nxt = r_pc;
            w_mem_req_nxt  = 1'b1;
            w_wait_cnt_nxt = {CNT_W{1'b0}};
            w_state_nxt    = ST_REQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_VALID;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign io_fetch.mem_addr  = r_mem_addr;
  assign io_fetch.mem_req   = r_mem_req;
  assign io_fetch.IR        = r_ir;
  assign io_fetch.ir_valid  = r_ir_valid;
  assign io_fetch.pc        = r_pc;
  assign io_fetch.fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
  localparam int ADDR_W  = 64;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(64'h0),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_fetch(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a fetch is either outstanding, delivered-but-unconsumed, or neither.
  logic [63:0] m_pc, m_addr, m_tgt;
  logic [31:0] m_ir;
  bit          m_busy, m_valid, m_err, m_pend;
  int          m_misses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch();
    m_busy   = 1'b1;
    m_addr   = m_pc;
    m_misses = 0;
  endtask

  task automatic model_edge();
    logic [63:0] tgt_in;
    tgt_in = bus.pc_in & ~64'h3;
    if (rst) begin
      m_pc = 64'h0; m_addr = 64'h0; m_ir = 32'h0;
      m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_misses = 0;
    end else if (m_busy) begin
      if (bus.pc_load) begin
        m_pend = 1'b1;
        m_tgt  = tgt_in;
      end
      if (bus.mem_ack) begin
        if (m_pend) m_pc = m_tgt;
        else begin
          m_ir    = bus.mem_rdata;
          m_pc    = m_pc + 64'd4;
          m_valid = 1'b1;
        end
        m_pend = 1'b0;
        m_busy = 1'b0;
      end else begin
        m_misses++;
        if (m_misses == TIMEOUT) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
          if (m_pend) m_pc = m_tgt;
          m_pend = 1'b0;
        end
      end
    end else if (bus.pc_load) begin
      m_pc    = tgt_in;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (bus.ir_ack) begin
        m_valid = 1'b0;
        if (bus.fetch_en) launch();
      end
    end else if (bus.fetch_en) begin
      launch();
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", bus.pc, m_pc);
    chk("mem_req", {63'd0, bus.mem_req}, {63'd0, m_busy});
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("ir", {32'd0, bus.IR}, {32'd0, m_ir});
    chk("ir_valid", {63'd0, bus.ir_valid}, {63'd0, m_valid});
    chk("fetch_err", {63'd0, bus.fetch_err}, {63'd0, m_err});
  endtask

  task automatic idle_in();
    bus.fetch_en  = 1'b0;
    bus.ir_ack    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_in     = 64'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_tgt = 64'h0;
    idle_in();
    rst = 1'b1;
    #1;
    step();
    chk("rst_pc", bus.pc, 64'h0);
    chk("rst_req", {63'd0, bus.mem_req}, 64'd0);
    rst = 1'b0;

    // Single zero-wait fetch: request after one edge, valid after the next
    bus.fetch_en = 1'b1; step();
    chk("t1_req", {63'd0, bus.mem_req}, 64'd1);
    chk("t1_addr", bus.mem_addr, 64'h0);
    chk("t1_notyet", {63'd0, bus.ir_valid}, 64'd0);
    idle_in(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8B02_0020; step();
    chk("t1_ir", {32'd0, bus.IR}, 64'h8B02_0020);
    chk("t1_valid", {63'd0, bus.ir_valid}, 64'd1);
    chk("t1_pc", bus.pc, 64'h4);

    // Three back-to-back fetches with two wait states each
    idle_in(); rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle_in(); bus.fetch_en = 1'b1; bus.ir_ack = (i != 0); step();
      chk("b2b_addr", bus.mem_addr, 64'(4 * i));
      chk("b2b_req", {63'd0, bus.mem_req}, 64'd1);
      idle_in(); step(); step();
      chk("b2b_wait", {63'd0, bus.mem_req}, 64'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom; step();
      chk("b2b_valid", {63'd0, bus.ir_valid}, 64'd1);
    end
    chk("b2b_pc", bus.pc, 64'd12);

    // Redirect while VALID flushes IR and aligns target
    idle_in(); bus.pc_load = 1'b1; bus.pc_in = 64'h103; step();
    chk("rv_valid", {63'd0, bus.ir_valid}, 64'd0);
    chk("rv_pc", bus.pc, 64'h100);
    idle_in(); bus.fetch_en = 1'b1; step();
    chk("rv_addr", bus.mem_addr, 64'h100);
    idle_in(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222; step();
    chk("rv_pc2", bus.pc, 64'h104);

    // Redirect during REQ: ack three cycles later is discarded
    idle_in(); bus.ir_ack = 1'b1; bus.fetch_en = 1'b1; step();
    idle_in(); bus.pc_load = 1'b1; bus.pc_in = 64'h200; step();
    chk("rr_hold", bus.pc, 64'h104);
    idle_in(); step(); step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; step();
    chk("rr_ir", {32'd0, bus.IR}, 64'h1111_2222);
    chk("rr_valid", {63'd0, bus.ir_valid}, 64'd0);
    chk("rr_pc", bus.pc, 64'h200);
    idle_in(); bus.mem_ack = 1'b1; step();
    chk("rr_idle", {63'd0, bus.mem_req}, 64'd0);

    // Timeout: request drops after TIMEOUT unacknowledged cycles, error sticks
    idle_in(); bus.fetch_en = 1'b1; step();
    idle_in();
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      if (k == TIMEOUT - 1) chk("to_still", {63'd0, bus.mem_req}, 64'd1);
    end
    chk("to_drop", {63'd0, bus.mem_req}, 64'd0);
    chk("to_err", {63'd0, bus.fetch_err}, 64'd1);
    chk("to_pc", bus.pc, 64'h200);
    bus.fetch_en = 1'b1; step();
    idle_in(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; step();
    chk("to_sticky", {63'd0, bus.fetch_err}, 64'd1);
    chk("to_pc2", bus.pc, 64'h204);

    // Reset mid-REQ, then PC wrap at the top of the address space
    idle_in(); bus.ir_ack = 1'b1; bus.fetch_en = 1'b1; step();
    idle_in(); rst = 1'b1; step(); rst = 1'b0;
    chk("mr_req", {63'd0, bus.mem_req}, 64'd0);
    chk("mr_err", {63'd0, bus.fetch_err}, 64'd0);
    chk("mr_pc", bus.pc, 64'h0);
    bus.pc_load = 1'b1; bus.pc_in = 64'hFFFF_FFFF_FFFF_FFFF; step();
    chk("wr_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    idle_in(); bus.fetch_en = 1'b1; step();
    chk("wr_addr", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    idle_in(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013; step();
    chk("wr_pc2", bus.pc, 64'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      bus.fetch_en  = $urandom_range(0, 1) == 1;
      bus.ir_ack    = $urandom_range(0, 2) == 0;
      bus.pc_load   = $urandom_range(0, 9) == 0;
      bus.pc_in     = {$urandom, $urandom};
      bus.mem_ack   = $urandom_range(0, 2) == 0;
      bus.mem_rdata = $urandom;
      step();
    end
    rst = 1'b0;
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the multicycle control unit: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched 32-bit instruction in the IR that the control unit decodes. The control unit requests a fetch while in its fetch state, consumes the IR with a one-cycle acknowledge, and redirects the PC on taken branches.

## Interface
- ADDR_W, 64, PC and memory address width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 16, max REQ cycles without mem_ack before error (≥2)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fetch_en  in  1  control unit requests next instruction
- ir_ack  in  1  control unit has consumed IR (one-cycle pulse)
- pc_load  in  1  redirect PC (taken branch)
- pc_in  in  ADDR_W  redirect target
- mem_addr  out  ADDR_W  instruction memory address
- mem_req  out  1  read request, registered
- mem_ack  in  1  memory data valid this cycle
- mem_rdata  in  32  instruction word
- IR  out  32  instruction register
- ir_valid  out  1  IR holds an unconsumed instruction
- pc  out  ADDR_W  current PC (address of next fetch)
- fetch_err  out  1  sticky timeout flag

## Operation
- Reset: pc=RESET_PC, IR=0, ir_valid=0, mem_req=0, mem_addr=RESET_PC, fetch_err=0, state IDLE, pending-redirect flag cleared. Reset wins over all inputs, including mid-fetch.
- States: IDLE, REQ, VALID.
- IDLE: mem_req=0. pc_load → pc<=pc_in, stay IDLE. Else fetch_en → mem_addr<=pc, mem_req<=1, wait counter<=0, go REQ.
- REQ: mem_req and mem_addr held stable. mem_ack=1: IR<=mem_rdata, pc<=pc+4, mem_req<=0, ir_valid<=1, go VALID. No ack: counter++; on the TIMEOUT-th cycle without ack: mem_req<=0, fetch_err<=1, go IDLE, IR/pc unchanged.
- REQ with pc_load: target latched, pending flag set; request is not aborted. On ack: data discarded (IR, ir_valid unchanged), pc<=latched target, flag cleared, go IDLE. A later pc_load in REQ overwrites the latched target. Timeout with pending redirect: pc<=latched target, flag cleared.
- VALID: IR stable. ir_ack → ir_valid<=0; if fetch_en same cycle go REQ with mem_addr=pc (back-to-back), else IDLE. pc_load in VALID: pc<=pc_in, ir_valid<=0 (flush), go IDLE; pc_load overrides ir_ack/fetch_en.
- Priority each cycle: reset > pc_load > mem_ack/timeout > ir_ack > fetch_en.
- pc_in[1:0] ignored; pc low two bits always 0. pc+4 wraps modulo 2^ADDR_W.
- fetch_err only cleared by reset; fetching continues normally after it.

## Timing
- All outputs registered; no combinational path input→output.
- fetch_en at edge 0 (IDLE) → mem_req=1 after edge 0. mem_ack sampled at edge k (k≥1) → ir_valid=1, IR, pc+4 visible after edge k. Zero-wait memory: request to valid = 2 cycles.
- mem_ack ignored outside REQ.
- ir_ack at edge j → ir_valid=0 after edge j; with fetch_en, mem_req=1 after edge j.
- Redirect in IDLE/VALID takes effect after one edge; redirect during REQ after the ack edge.

## Test plan
- Reset then fetch_en, mem_ack one cycle after mem_req, mem_rdata=0x8B020020 → mem_addr=0, IR=0x8B020020, ir_valid=1, pc=4, 2-cycle latency.
- Three back-to-back fetches, ir_ack+fetch_en same cycle, 2 wait states each → addresses 0,4,8; pc=12; mem_req never drops between ack and next request beyond one cycle.
- pc_load pc_in=0x103 while VALID → ir_valid=0, pc=0x100; next fetch mem_addr=0x100.
- pc_load pc_in=0x200 during REQ, ack 3 cycles later with 0xDEADBEEF → IR unchanged, ir_valid=0, pc=0x200, state IDLE.
- No mem_ack, TIMEOUT=16 → mem_req drops after 16 REQ cycles, fetch_err=1, stays set across next successful fetch until reset.
- reset asserted mid-REQ → next cycle mem_req=0, ir_valid=0, pc=RESET_PC, fetch_err=0; pc=0xFFFFFFFFFFFFFFFC fetch wraps pc to 0.
